// File: rtl/fp_pkg.sv
// fp_pkg: shared IEEE-754 field defaults, operand classes and flag layout for the FP datapath
package fp_pkg;
  localparam int EXP_W_DEF = 8;
  localparam int MAN_W_DEF = 23;
  localparam logic [31:0] CANON_NAN_SP = 32'h7FC0_0000;
  localparam int FLAG_INV = 3;
  localparam int FLAG_OVF = 2;
  localparam int FLAG_UNF = 1;
  localparam int FLAG_INX = 0;
  typedef enum logic [2:0] {CLS_ZERO, CLS_NORM, CLS_INF, CLS_QNAN, CLS_SNAN} fpClass_e;
  function automatic int bias(input int expW);
    return (1 << (expW - 1)) - 1;
  endfunction
  // exp=0 classifies as zero: denormals are flushed
  function automatic fpClass_e classify(input logic expZero, input logic expOnes, input logic manZero,
                                        input logic manMsb);
    return expZero ? CLS_ZERO : !expOnes ? CLS_NORM : manZero ? CLS_INF : manMsb ? CLS_QNAN : CLS_SNAN;
  endfunction
endpackage

// File: rtl/fp_add_pipe_if.sv
// fp_add_pipe_if: operand/result valid-ready bus of the pipelined FP adder
interface fp_add_pipe_if
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
);
  localparam int W = 1 + EXP_W + MAN_W;
  logic in_valid, in_ready, op_sub, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic [3:0] flags;
  modport master(output in_valid, op_sub, a, b, out_ready, input in_ready, out_valid, sum, flags);
  modport slave(input in_valid, op_sub, a, b, out_ready, output in_ready, out_valid, sum, flags);
endinterface

// File: rtl/fp_lzc.sv
// fp_lzc: leading-zero count of a WIDTH-bit vector, WIDTH when the vector is all zero
module fp_lzc #(
  parameter int WIDTH = 27,
  localparam int CW = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] vec,
  output logic [CW-1:0]    cnt
);
  always_comb begin
    cnt = CW'(WIDTH);
    for (int i = 0; i < WIDTH; i++) if (vec[i]) cnt = CW'(WIDTH - 1 - i);
  end
endmodule

// File: rtl/fp_add_pipe.sv
// fp_add_pipe: 3-stage IEEE-754 adder/subtractor, RNE rounding, flush-to-zero, valid/ready flow control
module fp_add_pipe
  import fp_pkg::*;
#(
  parameter int EXP_W = EXP_W_DEF,
  parameter int MAN_W = MAN_W_DEF
) (
  input logic clk,
  input logic rst_n,
  fp_add_pipe_if.slave bus
);
  localparam int W = 1 + EXP_W + MAN_W;
  localparam int MW = MAN_W + 4;
  localparam int CW = $clog2(MW + 1);
  localparam logic [EXP_W-1:0] EXP_ONES = '1;
  localparam logic [W-1:0] QNAN = {1'b0, EXP_ONES, 1'b1, {(MAN_W - 1){1'b0}}};
  localparam logic [3:0] INV = 4'b1 << FLAG_INV;
  localparam logic [3:0] OVF = 4'b1 << FLAG_OVF;
  localparam logic [3:0] UNF = 4'b1 << FLAG_UNF;
  localparam logic [3:0] INX = 4'b1 << FLAG_INX;
  logic s1Valid, s2Valid, s3Valid, s1Adv, s2Adv, s3Adv;
  assign s3Adv = s3Valid & bus.out_ready;
  assign s2Adv = s2Valid & (!s3Valid | s3Adv);
  assign s1Adv = s1Valid & (!s2Valid | s2Adv);
  assign bus.in_ready = !s1Valid | s1Adv;
  logic signA, signB, swap, signL, effSub, nanIn, snanIn, infClash, special;
  logic [EXP_W-1:0] expA, expB, expL, expS, diff;
  logic [MAN_W-1:0] manA, manB;
  logic [MW-1:0] mL, mS, alignS;
  logic [W-1:0] specVal;
  logic [3:0] specFlags;
  fpClass_e clsA, clsB;
  assign signA = bus.a[W-1];
  assign signB = bus.b[W-1] ^ bus.op_sub;
  assign expA = bus.a[W-2:MAN_W];
  assign expB = bus.b[W-2:MAN_W];
  assign manA = expA == '0 ? '0 : bus.a[MAN_W-1:0];
  assign manB = expB == '0 ? '0 : bus.b[MAN_W-1:0];
  assign clsA = classify(expA == '0, expA == EXP_ONES, bus.a[MAN_W-1:0] == '0, bus.a[MAN_W-1]);
  assign clsB = classify(expB == '0, expB == EXP_ONES, bus.b[MAN_W-1:0] == '0, bus.b[MAN_W-1]);
  assign swap = {expB, manB} > {expA, manA};
  assign signL = swap ? signB : signA;
  assign expL = swap ? expB : expA;
  assign expS = swap ? expA : expB;
  assign diff = expL - expS;
  assign mL = {expL != '0, swap ? manB : manA, 3'b000};
  assign mS = {expS != '0, swap ? manA : manB, 3'b000};
  // far-away operands only ever contribute a sticky bit
  assign alignS = 32'(diff) >= MAN_W + 3 ? MW'(|mS) : (mS >> diff) | MW'(|(mS & ~({MW{1'b1}} << diff)));
  assign effSub = signA ^ signB;
  assign nanIn = clsA inside {CLS_QNAN, CLS_SNAN} || clsB inside {CLS_QNAN, CLS_SNAN};
  assign snanIn = clsA == CLS_SNAN || clsB == CLS_SNAN;
  assign infClash = clsA == CLS_INF && clsB == CLS_INF && effSub;
  assign special = nanIn || clsA == CLS_INF || clsB == CLS_INF;
  assign specVal = nanIn || infClash ? QNAN : {signL, EXP_ONES, {MAN_W{1'b0}}};
  assign specFlags = snanIn || infClash ? INV : 4'b0;
  logic r1Sign, r1Sub, r1Spec;
  logic [EXP_W-1:0] r1Exp;
  logic [MW-1:0] r1ML, r1MS;
  logic [W-1:0] r1SpecVal;
  logic [3:0] r1SpecFlags;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s1Valid <= 1'b0;
      {r1Sign, r1Sub, r1Spec, r1Exp, r1ML, r1MS, r1SpecVal, r1SpecFlags} <= '0;
    end else if (bus.in_ready) begin
      s1Valid <= bus.in_valid;
      {r1Sign, r1Sub, r1Spec, r1Exp} <= {signL, effSub, special, expL};
      {r1ML, r1MS, r1SpecVal, r1SpecFlags} <= {mL, alignS, specVal, specFlags};
    end
  // larger magnitude always sits in r1ML, so the subtraction never goes negative
  logic [MW:0] mag2;
  logic [CW-1:0] lzc2;
  assign mag2 = r1Sub ? {1'b0, r1ML} - {1'b0, r1MS} : {1'b0, r1ML} + {1'b0, r1MS};
  fp_lzc #(.WIDTH(MW)) lzc (.vec(mag2[MW-1:0]), .cnt(lzc2));
  logic r2Sign, r2Sub, r2Spec;
  logic [EXP_W-1:0] r2Exp;
  logic [MW:0] r2Mag;
  logic [CW-1:0] r2Lzc;
  logic [W-1:0] r2SpecVal;
  logic [3:0] r2SpecFlags;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s2Valid <= 1'b0;
      {r2Sign, r2Sub, r2Spec, r2Exp, r2Mag, r2Lzc, r2SpecVal, r2SpecFlags} <= '0;
    end else if (!s2Valid || s2Adv) begin
      s2Valid <= s1Valid;
      {r2Sign, r2Sub, r2Spec, r2Exp} <= {r1Sign, r1Sub, r1Spec, r1Exp};
      {r2Mag, r2Lzc, r2SpecVal, r2SpecFlags} <= {mag2, lzc2, r1SpecVal, r1SpecFlags};
    end
  logic carry, magZero, unf, ovf, rUp;
  logic [MW-1:0] norm;
  logic [EXP_W+1:0] expN, expR;
  logic [MAN_W+1:0] manR;
  logic [W-1:0] res;
  logic [3:0] flg;
  assign carry = r2Mag[MW];
  assign magZero = r2Mag == '0;
  assign unf = !carry && {2'b0, r2Exp} <= (EXP_W + 2)'(r2Lzc);
  assign norm = carry ? {r2Mag[MW:2], r2Mag[1] | r2Mag[0]} : r2Mag[MW-1:0] << r2Lzc;
  assign expN = carry ? {2'b0, r2Exp} + (EXP_W + 2)'(1) : {2'b0, r2Exp} - (EXP_W + 2)'(r2Lzc);
  assign rUp = norm[2] & (norm[1] | norm[0] | norm[3]);
  assign manR = {1'b0, norm[MW-1:3]} + (MAN_W + 2)'(rUp);
  assign expR = expN + (EXP_W + 2)'(manR[MAN_W+1]);
  assign ovf = expR >= {2'b0, EXP_ONES};
  assign res = r2Spec ? r2SpecVal : magZero ? {!r2Sub & r2Sign, {(W - 1){1'b0}}} :
               unf ? {r2Sign, {(W - 1){1'b0}}} : ovf ? {r2Sign, EXP_ONES, {MAN_W{1'b0}}} :
               {r2Sign, expR[EXP_W-1:0], manR[MAN_W-1:0]};
  assign flg = r2Spec ? r2SpecFlags : magZero ? 4'b0 : unf ? UNF | INX : ovf ? OVF | INX :
               (|norm[2:0] ? INX : 4'b0);
  logic [W-1:0] sumR;
  logic [3:0] flagsR;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      s3Valid <= 1'b0;
      sumR <= '0;
      flagsR <= '0;
    end else if (!s3Valid || s3Adv) begin
      s3Valid <= s2Valid;
      sumR <= res;
      flagsR <= flg;
    end
  assign bus.out_valid = s3Valid;
  assign bus.sum = sumR;
  assign bus.flags = flagsR;
endmodule

// File: tb/tb_fp_add_pipe.sv
// tb_fp_add_pipe: table-driven vectors for fp_add_pipe plus stall and mid-stream reset sequences
module tb_fp_add_pipe;
  typedef struct {
    logic sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sum;
    logic [3:0] flags;
  } vec_t;
  localparam int NV = 20;
  vec_t vecs[NV];
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int nApplied = 0;
  int nMiss = 0;
  always #5 clk = ~clk;
  fp_add_pipe_if bus ();
  fp_add_pipe dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  task automatic check(input string name, input logic [39:0] got, input logic [39:0] exp);
    nApplied++;
    if (got !== exp) begin
      nMiss++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask
  task automatic drive(input int i);
    bus.op_sub = vecs[i].sub;
    bus.a = vecs[i].a;
    bus.b = vecs[i].b;
  endtask
  task automatic runVec(input int i);
    int w = 0;
    int lat = 1;
    @(negedge clk);
    bus.in_valid = 1'b1;
    drive(i);
    #1;
    while (!bus.in_ready && w < 20) begin
      @(negedge clk);
      #1;
      w++;
    end
    @(negedge clk);
    bus.in_valid = 1'b0;
    #1;
    while (!bus.out_valid && lat < 20) begin
      @(negedge clk);
      #1;
      lat++;
    end
    check($sformatf("vec%0d", i), 40'({bus.sum, bus.flags}), 40'({vecs[i].sum, vecs[i].flags}));
    check($sformatf("vec%0d_latency", i), 40'(lat), 40'(3));
  endtask
  task automatic flowTest();
    int k = 0;
    int got = 0;
    int c = 0;
    int lowAt = -1;
    int gaps = 0;
    int unstable = 0;
    while (got < 6 && c < 60) begin
      @(negedge clk);
      bus.out_ready = !(c >= 2 && c <= 7);
      bus.in_valid = k < 6;
      if (k < 6) drive(k);
      #1;
      if (!bus.in_ready && lowAt < 0) lowAt = k - got;
      if (bus.out_valid && !bus.out_ready && {bus.sum, bus.flags} !== {vecs[got].sum, vecs[got].flags})
        unstable++;
      if (got > 0 && bus.out_ready && !bus.out_valid) gaps++;
      if (bus.out_valid && bus.out_ready) begin
        check($sformatf("flow%0d", got), 40'({bus.sum, bus.flags}), 40'({vecs[got].sum, vecs[got].flags}));
        got++;
      end
      if (bus.in_valid && bus.in_ready) k++;
      c++;
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    check("flow_count", 40'(got), 40'(6));
    check("flow_held_when_ready_low", 40'(lowAt), 40'(3));
    check("flow_gaps", 40'(gaps), 40'(0));
    check("flow_stall_hold", 40'(unstable), 40'(0));
  endtask
  task automatic resetTest();
    int stale = 0;
    @(negedge clk);
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    drive(2);
    repeat (3) @(negedge clk);
    #1;
    check("pre_reset_valid", 40'(bus.out_valid), 40'(1));
    #1;
    rst_n = 1'b0;
    #1;
    check("reset_async", 40'({bus.out_valid, bus.sum, bus.flags}), 40'(0));
    bus.in_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", 40'(bus.in_ready), 40'(1));
    repeat (8) begin
      @(negedge clk);
      #1;
      if (bus.out_valid) stale++;
    end
    check("reset_no_stale", 40'(stale), 40'(0));
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    vecs[0]  = '{1'b0, 32'h3F800000, 32'h40000000, 32'h40400000, 4'h0};
    vecs[1]  = '{1'b1, 32'h3F800000, 32'h3F800000, 32'h00000000, 4'h0};
    vecs[2]  = '{1'b0, 32'hC0000000, 32'h3F800000, 32'hBF800000, 4'h0};
    vecs[3]  = '{1'b0, 32'h3F800000, 32'h33800000, 32'h3F800000, 4'h1};
    vecs[4]  = '{1'b0, 32'h3F800001, 32'h33800000, 32'h3F800002, 4'h1};
    vecs[5]  = '{1'b0, 32'h7F7FFFFF, 32'h7F7FFFFF, 32'h7F800000, 4'h5};
    vecs[6]  = '{1'b0, 32'h7F800000, 32'hFF800000, 32'h7FC00000, 4'h8};
    vecs[7]  = '{1'b0, 32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'h8};
    vecs[8]  = '{1'b0, 32'h00400000, 32'h00000000, 32'h00000000, 4'h0};
    vecs[9]  = '{1'b1, 32'h00800000, 32'h00800001, 32'h80000000, 4'h3};
    vecs[10] = '{1'b0, 32'h80000000, 32'h80000000, 32'h80000000, 4'h0};
    vecs[11] = '{1'b0, 32'h7FC00000, 32'h3F800000, 32'h7FC00000, 4'h0};
    vecs[12] = '{1'b0, 32'hFF800000, 32'h3F800000, 32'hFF800000, 4'h0};
    vecs[13] = '{1'b1, 32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'h8};
    vecs[14] = '{1'b0, 32'h3F800000, 32'h33800001, 32'h3F800001, 4'h1};
    vecs[15] = '{1'b0, 32'h3FFFFFFF, 32'h33800000, 32'h40000000, 4'h1};
    vecs[16] = '{1'b0, 32'h3F800000, 32'h3F800000, 32'h40000000, 4'h0};
    vecs[17] = '{1'b0, 32'h4C800000, 32'h3F800000, 32'h4C800000, 4'h1};
    vecs[18] = '{1'b0, 32'h3F800000, 32'h80000000, 32'h3F800000, 4'h0};
    vecs[19] = '{1'b1, 32'h40400000, 32'h3F800000, 32'h40000000, 4'h0};
    bus.in_valid = 1'b0;
    bus.op_sub = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.out_ready = 1'b1;
    repeat (2) @(negedge clk);
    check("reset_outputs", 40'({bus.out_valid, bus.sum, bus.flags}), 40'(0));
    rst_n = 1'b1;
    #1;
    check("release_in_ready", 40'(bus.in_ready), 40'(1));
    for (int i = 0; i < NV; i++) runVec(i);
    flowTest();
    resetTest();
    runVec(0);
    $display("== %0d vectors applied, %0d miscompares ==", nApplied, nMiss);
    $finish;
  end
endmodule
